// File: rtl/core_seq_pkg.sv
// Shared types and constants for the convolution core sequencer: FSM states,
// instruction-word field positions and the idle instruction word.
package core_seq_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StWld,
    StKld,
    StKwait,
    StAld,
    StExe,
    StDrain,
    StNext,
    StDone
  } state_e;

  localparam int unsigned InstW      = 34;
  localparam int unsigned AddrFieldW = 11;

  localparam int unsigned AccBit     = 33;
  localparam int unsigned CenPBit    = 32;
  localparam int unsigned WenPBit    = 31;
  localparam int unsigned APLsb      = 20;
  localparam int unsigned CenXBit    = 19;
  localparam int unsigned WenXBit    = 18;
  localparam int unsigned AXLsb      = 7;
  localparam int unsigned OfifoRdBit = 6;
  localparam int unsigned IfifoWrBit = 5;
  localparam int unsigned IfifoRdBit = 4;
  localparam int unsigned L0RdBit    = 3;
  localparam int unsigned L0WrBit    = 2;
  localparam int unsigned ExecBit    = 1;
  localparam int unsigned LoadBit    = 0;

  // Both memories deselected and write-disabled, everything else quiet.
  localparam logic [InstW-1:0] IdleWord = 34'h1800C0000;

endpackage

// File: rtl/core_seq_inst_pack.sv
// Combinational packer that places the named instruction fields into the
// 34-bit core instruction word.
module core_seq_inst_pack
  import core_seq_pkg::*;
(
  input  logic                  acc,
  input  logic                  cen_pmem,
  input  logic                  wen_pmem,
  input  logic [AddrFieldW-1:0] a_pmem,
  input  logic                  cen_xmem,
  input  logic                  wen_xmem,
  input  logic [AddrFieldW-1:0] a_xmem,
  input  logic                  ofifo_rd,
  input  logic                  ififo_wr,
  input  logic                  ififo_rd,
  input  logic                  l0_rd,
  input  logic                  l0_wr,
  input  logic                  execute,
  input  logic                  load,
  output logic [InstW-1:0]      inst
);

  always_comb begin
    inst                          = '0;
    inst[AccBit]                  = acc;
    inst[CenPBit]                 = cen_pmem;
    inst[WenPBit]                 = wen_pmem;
    inst[APLsb +: AddrFieldW]     = a_pmem;
    inst[CenXBit]                 = cen_xmem;
    inst[WenXBit]                 = wen_xmem;
    inst[AXLsb +: AddrFieldW]     = a_xmem;
    inst[OfifoRdBit]              = ofifo_rd;
    inst[IfifoWrBit]              = ififo_wr;
    inst[IfifoRdBit]              = ififo_rd;
    inst[L0RdBit]                 = l0_rd;
    inst[L0WrBit]                 = l0_wr;
    inst[ExecBit]                 = execute;
    inst[LoadBit]                 = load;
  end

endmodule

// File: rtl/core_seq.sv
// Convolution core sequencer: walks kernel positions issuing weight load, activation
// execute and psum drain instructions. Define CORE_SEQ_ACC_EN to accumulate psums.
module core_seq
  import core_seq_pkg::*;
#(
  parameter int unsigned ROW = 8,
  parameter int unsigned COL = 8,
  parameter int unsigned AW  = 11,
  parameter int unsigned CW  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CW-1:0]    num_kij,
  input  logic [CW-1:0]    len_nij,
  input  logic [AW-1:0]    w_base,
  input  logic [AW-1:0]    a_base,
  input  logic [AW-1:0]    p_base,
  input  logic             ofifo_valid,
  output logic [InstW-1:0] inst,
  output logic             busy,
  output logic             done
);

  // One extra bit so the ALD index can reach len_nij at its maximum.
  localparam int unsigned CntW = CW + 1;
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] WldLast   = CntW'(COL);
  localparam logic [CntW-1:0] KldLast   = CntW'(COL - 1);
  localparam logic [CntW-1:0] KwaitLast = CntW'(ROW + COL - 1);
  localparam logic [CntW-1:0] ColCnt    = CntW'(COL);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [CW-1:0]   kij_q, kij_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d;
  logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
  logic            pend_q, pend_d;
  logic [CW-1:0]   num_kij_q, len_q;
  logic [AW-1:0]   w_base_q, a_base_q, p_base_q;

  logic            accept, rd_fire;
  logic [CntW-1:0] len_cnt;
  logic [AW-1:0]   w_addr, a_addr, p_addr;

  logic            f_acc, f_cen_p, f_wen_p, f_cen_x, f_wen_x;
  logic [AW-1:0]   f_a_p, f_a_x;
  logic            f_ofifo_rd, f_l0_rd, f_l0_wr, f_exec, f_load;
  logic [InstW-1:0] inst_d;

  assign len_cnt = {1'b0, len_q};
  assign rd_fire = (state_q == StDrain) && ofifo_valid && (rd_cnt_q < len_q);
  assign w_addr  = w_base_q + AW'(kij_q * COL) + AW'(cnt_q);
  assign a_addr  = a_base_q + AW'(cnt_q);
  assign p_addr  = p_base_q + AW'(wr_cnt_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kij_d    = kij_q;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    pend_d   = pend_q;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // done is still visible in the cycle after DONE; start stays ignored there.
        if (start && !done) begin
          accept  = 1'b1;
          kij_d   = '0;
          cnt_d   = '0;
          state_d = (num_kij == '0 || len_nij == '0) ? StDone : StWld;
        end
      end
      StWld: begin
        if (cnt_q == WldLast) begin
          cnt_d   = '0;
          state_d = StKld;
        end else cnt_d = cnt_q + CntOne;
      end
      StKld: begin
        if (cnt_q == KldLast) begin
          cnt_d   = '0;
          state_d = StKwait;
        end else cnt_d = cnt_q + CntOne;
      end
      StKwait: begin
        if (cnt_q == KwaitLast) begin
          cnt_d   = '0;
          state_d = StAld;
        end else cnt_d = cnt_q + CntOne;
      end
      StAld: begin
        if (cnt_q == len_cnt) begin
          cnt_d   = '0;
          state_d = StExe;
        end else cnt_d = cnt_q + CntOne;
      end
      StExe: begin
        if (cnt_q + CntOne == len_cnt) begin
          cnt_d    = '0;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          pend_d   = 1'b0;
          state_d  = StDrain;
        end else cnt_d = cnt_q + CntOne;
      end
      StDrain: begin
        if (rd_fire) rd_cnt_d = rd_cnt_q + CW'(1);
        pend_d = rd_fire;
        if (pend_q) begin
          wr_cnt_d = wr_cnt_q + CW'(1);
          if (wr_cnt_q + CW'(1) == len_q) state_d = StNext;
        end
      end
      StNext: begin
        if (kij_q == num_kij_q - CW'(1)) begin
          state_d = StDone;
        end else begin
          kij_d   = kij_q + CW'(1);
          cnt_d   = '0;
          state_d = StWld;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    f_acc      = 1'b0;
    f_cen_p    = 1'b1;
    f_wen_p    = 1'b1;
    f_a_p      = '0;
    f_cen_x    = 1'b1;
    f_wen_x    = 1'b1;
    f_a_x      = '0;
    f_ofifo_rd = 1'b0;
    f_l0_rd    = 1'b0;
    f_l0_wr    = 1'b0;
    f_exec     = 1'b0;
    f_load     = 1'b0;
    unique case (state_q)
      StWld: begin
        if (cnt_q < ColCnt) begin
          f_cen_x = 1'b0;
          f_a_x   = w_addr;
        end
        f_l0_wr = (cnt_q != '0);
      end
      StKld: begin
        f_l0_rd = 1'b1;
        f_load  = 1'b1;
      end
      StAld: begin
        if (cnt_q < len_cnt) begin
          f_cen_x = 1'b0;
          f_a_x   = a_addr;
        end
        f_l0_wr = (cnt_q != '0);
      end
      StExe: begin
        f_l0_rd = 1'b1;
        f_exec  = 1'b1;
      end
      StDrain: begin
        f_ofifo_rd = rd_fire;
        if (pend_q) begin
          f_cen_p = 1'b0;
          f_wen_p = 1'b0;
          f_a_p   = p_addr;
`ifdef CORE_SEQ_ACC_EN
          f_acc   = (kij_q != '0);
`else
          f_acc   = 1'b0;
`endif
        end
      end
      default: ;
    endcase
  end

  core_seq_inst_pack u_inst_pack (
    .acc      (f_acc),
    .cen_pmem (f_cen_p),
    .wen_pmem (f_wen_p),
    .a_pmem   (AddrFieldW'(f_a_p)),
    .cen_xmem (f_cen_x),
    .wen_xmem (f_wen_x),
    .a_xmem   (AddrFieldW'(f_a_x)),
    .ofifo_rd (f_ofifo_rd),
    .ififo_wr (1'b0),
    .ififo_rd (1'b0),
    .l0_rd    (f_l0_rd),
    .l0_wr    (f_l0_wr),
    .execute  (f_exec),
    .load     (f_load),
    .inst     (inst_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      kij_q    <= '0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      pend_q   <= 1'b0;
      inst     <= IdleWord;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      kij_q    <= kij_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      pend_q   <= pend_d;
      inst     <= inst_d;
      busy     <= accept || !(state_q inside {StIdle, StDone});
      done     <= (state_q == StDone);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_kij_q <= '0;
      len_q     <= '0;
      w_base_q  <= '0;
      a_base_q  <= '0;
      p_base_q  <= '0;
    end else if (accept) begin
      num_kij_q <= num_kij;
      len_q     <= len_nij;
      w_base_q  <= w_base;
      a_base_q  <= a_base;
      p_base_q  <= p_base;
    end
  end

endmodule

// File: tb/tb_core_seq.sv
// Scoreboard bench for core_seq: expected memory-access streams are queued at start,
// a negedge monitor pops and compares them as the DUT issues instructions.
module tb_core_seq;

  localparam int COL = 8;
  localparam int AMOD = 2048;
  localparam logic [33:0] IDLE = 34'h1800C0000;
`ifdef CORE_SEQ_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk, reset, start, ofifo_valid;
  logic [7:0]  num_kij, len_nij;
  logic [10:0] w_base, a_base, p_base;
  logic [33:0] inst;
  logic        busy, done;

  core_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_kij     (num_kij),
    .len_nij     (len_nij),
    .w_base      (w_base),
    .a_base      (a_base),
    .p_base      (p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0, n_fail = 0;
  int xq[$];
  int pq[$];
  bit mon_en = 1'b1;
  int cyc = 0, busy_rise_cyc = 0, done_cyc = 0;
  int n_done = 0, n_load = 0, n_exec = 0, n_l0rd = 0, n_l0wr = 0, n_rd = 0, n_wr = 0;
  int n_nonidle = 0;
  bit prev_busy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_busy = 1'b0;
      end else begin
        if (busy && !prev_busy) busy_rise_cyc = cyc;
        prev_busy = busy;
        if (done) begin
          n_done++;
          done_cyc = cyc;
          chk("busy_low_in_done", 64'(busy), 64'(0));
        end
        if (!busy) chk("idle_word_when_not_busy", 64'(inst), 64'(IDLE));
        if (inst != IDLE) n_nonidle++;
        if (inst[0]) n_load++;
        if (inst[1]) n_exec++;
        if (inst[2]) n_l0wr++;
        if (inst[3]) n_l0rd++;
        if (inst[6]) n_rd++;
        if (!inst[32]) n_wr++;
        if (mon_en) begin
          if (!inst[19]) begin
            chk("xmem_wen_high", 64'(inst[18]), 64'(1));
            chk("xmem_read_expected", 64'(xq.size() != 0), 64'(1));
            if (xq.size() != 0) chk("xmem_addr", 64'(inst[17:7]), 64'(xq.pop_front()));
          end
          if (!inst[32]) begin
            chk("pmem_wen_low", 64'(inst[31]), 64'(0));
            chk("pmem_write_expected", 64'(pq.size() != 0), 64'(1));
            if (pq.size() != 0) chk("pmem_acc_addr", 64'({inst[33], inst[30:20]}),
                                    64'(pq.pop_front()));
          end else begin
            chk("acc_only_on_write", 64'(inst[33]), 64'(0));
          end
        end
      end
    end
  end

  task automatic run(input int nk, input int ln, input int wb, input int ab, input int pb,
                     input int vmode, input bit extra);
    int d0, ld0, ex0, lr0, lw0, r0, w0, ni0, r1, w1;
    bit empty, stalled, extra_done;
    d0 = n_done; ld0 = n_load; ex0 = n_exec; lr0 = n_l0rd; lw0 = n_l0wr;
    r0 = n_rd; w0 = n_wr; ni0 = n_nonidle;
    empty = (nk == 0 || ln == 0);
    if (!empty) begin
      for (int k = 0; k < nk; k++) begin
        for (int c = 0; c < COL; c++) xq.push_back((wb + k * COL + c) % AMOD);
        for (int n = 0; n < ln; n++) xq.push_back((ab + n) % AMOD);
        for (int o = 0; o < ln; o++)
          pq.push_back(((ACC_EN && k > 0) ? AMOD : 0) + ((pb + o) % AMOD));
      end
    end
    @(posedge clk); #1;
    num_kij = 8'(nk); len_nij = 8'(ln);
    w_base = 11'(wb); a_base = 11'(ab); p_base = 11'(pb);
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    // Scramble the inputs: the run must use the values captured at start.
    num_kij = 8'($urandom); len_nij = 8'($urandom);
    w_base = 11'($urandom); a_base = 11'($urandom); p_base = 11'($urandom);
    stalled = 1'b0;
    extra_done = 1'b0;
    for (int i = 0; i < 6000 && n_done == d0; i++) begin
      if (vmode == 1) ofifo_valid = ($urandom_range(0, 2) != 0);
      if (vmode == 2 && !stalled && n_rd > r0) begin
        stalled = 1'b1;
        ofifo_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        r1 = n_rd; w1 = n_wr;
        repeat (18) @(posedge clk);
        #1;
        chk("stall_no_ofifo_rd", 64'(n_rd - r1), 64'(0));
        chk("stall_no_pmem_write", 64'(n_wr - w1), 64'(0));
        ofifo_valid = 1'b1;
      end
      if (extra && !extra_done && n_load > ld0) begin
        extra_done = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        num_kij = 8'd5; len_nij = 8'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    ofifo_valid = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("done_once", 64'(n_done - d0), 64'(1));
    chk("busy_low_after_run", 64'(busy), 64'(0));
    chk("xmem_queue_drained", 64'(xq.size()), 64'(0));
    chk("pmem_queue_drained", 64'(pq.size()), 64'(0));
    chk("load_cycles", 64'(n_load - ld0), 64'(empty ? 0 : nk * COL));
    chk("exec_cycles", 64'(n_exec - ex0), 64'(empty ? 0 : nk * ln));
    chk("l0_rd_cycles", 64'(n_l0rd - lr0), 64'(empty ? 0 : nk * (COL + ln)));
    chk("l0_wr_cycles", 64'(n_l0wr - lw0), 64'(empty ? 0 : nk * (COL + ln)));
    chk("ofifo_rd_cycles", 64'(n_rd - r0), 64'(empty ? 0 : nk * ln));
    chk("pmem_writes", 64'(n_wr - w0), 64'(empty ? 0 : nk * ln));
    if (empty) begin
      chk("empty_idle_word_held", 64'(n_nonidle - ni0), 64'(0));
      chk("empty_done_after_busy", 64'(done_cyc - busy_rise_cyc), 64'(1));
    end
    xq.delete();
    pq.delete();
  endtask

  task automatic reset_mid_exe();
    int e0, d0;
    mon_en = 1'b0;
    e0 = n_exec; d0 = n_done;
    @(posedge clk); #1;
    num_kij = 8'd2; len_nij = 8'd6; w_base = '0; a_base = 11'd64; p_base = '0;
    ofifo_valid = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 500 && n_exec == e0; i++) @(posedge clk);
    chk("reached_exe", 64'(n_exec > e0), 64'(1));
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("reset_inst_async", 64'(inst), 64'(IDLE));
    chk("reset_busy_async", 64'(busy), 64'(0));
    chk("reset_done_async", 64'(done), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    chk("no_done_after_reset", 64'(n_done - d0), 64'(0));
    chk("idle_after_reset", 64'(busy), 64'(0));
    mon_en = 1'b1;
  endtask

  initial begin : main
    int nk, ln;
    reset = 1'b1; start = 1'b0; ofifo_valid = 1'b1;
    num_kij = '0; len_nij = '0; w_base = '0; a_base = '0; p_base = '0;
    @(posedge clk); #1;
    chk("reset_inst", 64'(inst), 64'(IDLE));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(done), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run(1, 4, 0, 64, 0, 0, 1'b0);
    run(0, 5, 3, 9, 12, 0, 1'b0);
    run(3, 5, 100, 300, 500, 0, 1'b0);
    run(2, 8, 10, 20, 30, 2, 1'b0);
    run(1, 16, 0, 64, 2040, 0, 1'b1);
    reset_mid_exe();
    run(2, 3, 2044, 2046, 7, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      nk = $urandom_range(1, 3);
      ln = $urandom_range(0, 8);
      run(nk, ln, $urandom_range(0, AMOD - 1), $urandom_range(0, AMOD - 1),
          $urandom_range(0, AMOD - 1), 1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/core_seq.md
CORE_SEQ -- requirements
Module: core_seq

Interface
REQ-001 Parameters, each given as name, default, meaning:
- ROW, 8, PE array rows.
- COL, 8, PE array columns.
- AW, 11, SRAM address width.
- CW, 8, width of the loop counters.
REQ-002 Ports, each given as name, direction, width, meaning:
- clk, in, 1, single clock; all state changes on its rising edge.
- reset, in, 1, asynchronous, active-high.
REQ-003 start, in, 1: one-cycle pulse that launches a convolution run.
REQ-004 num_kij, in, CW: number of kernel positions; sampled at start.
REQ-005 len_nij, in, CW: number of activation vectors per kernel position; sampled at start.
REQ-006 w_base, in, AW: xmem base address of the weights; sampled at start.
REQ-007 a_base, in, AW: xmem base address of the activations; sampled at start.
REQ-008 p_base, in, AW: pmem base address of the psums; sampled at start.
REQ-009 ofifo_valid, in, 1: the core output FIFO holds a full row.
REQ-010 inst, out, 34: core instruction word. Field layout:
- [33] acc
- [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem
- [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem
- [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd
- [3] l0_rd, [2] l0_wr, [1] execute, [0] load
REQ-011 busy, out, 1: high from the cycle after an accepted start until DONE is exited.
REQ-012 done, out, 1: one-cycle pulse when the run completes.

Function
REQ-013 inst, busy and done shall all be registered outputs.
REQ-014 The idle word is 34'h1800C0000: CEN and WEN of both memories high, all other bits 0. This word shall be driven in every cycle not listed below.
REQ-015 States are IDLE, WLD, KLD, KWAIT, ALD, EXE, DRAIN, NEXT and DONE. kij counts from 0 to num_kij-1.
REQ-016 IDLE: start moves to WLD with kij=0. If the latched num_kij==0 or len_nij==0, go directly to DONE with no memory access.
REQ-017 WLD lasts COL+1 cycles, indexed c=0..COL.
- For c<COL: CEN_xmem=0, A_xmem=w_base+kij*COL+c.
- For c>=1: l0_wr=1, to cover the 1-cycle SRAM read latency.
REQ-018 KLD lasts COL cycles with l0_rd=1 and load=1.
REQ-019 KWAIT lasts ROW+COL cycles of idle word while the weights propagate.
REQ-020 ALD lasts len_nij+1 cycles, indexed n=0..len_nij.
- For n<len_nij: CEN_xmem=0, A_xmem=a_base+n.
- For n>=1: l0_wr=1.
REQ-021 EXE lasts len_nij cycles with l0_rd=1 and execute=1.
REQ-022 DRAIN cycle behaviour:
- Each cycle with ofifo_valid=1 asserts ofifo_rd.
- The next cycle writes pmem: CEN_pmem=0, WEN_pmem=0, A_pmem=p_base+o, where o is the output index.
- After len_nij writes, go to NEXT.
- ofifo_valid low stalls DRAIN indefinitely with no timeout.
REQ-023 The DRAIN write cycle and the next ofifo_rd may coincide in the same inst word.
REQ-024 NEXT transition: if kij==num_kij-1 go to DONE, otherwise kij+1 and go to WLD.
REQ-025 DONE holds done=1 and busy=0 for one cycle, then returns to IDLE.
REQ-026 start is ignored while not in IDLE, including in the DONE cycle.
REQ-027 Address arithmetic is modulo 2^AW; wrap-around is silent.
REQ-028 Latched configuration shall not change mid-run.

Reset
REQ-029 On reset assertion, asynchronously and in any state:
- state returns to IDLE;
- counters clear to 0;
- inst returns to 34'h1800C0000;
- busy=0 and done=0.
REQ-030 Reset mid-run discards the run. No done pulse is issued.

Configuration
REQ-031 With CORE_SEQ_ACC_EN defined, acc=1 on DRAIN pmem-write cycles whenever kij>0, so pmem accumulates across kernel positions.
REQ-032 Without CORE_SEQ_ACC_EN, acc is constant 0 and each kij overwrites p_base..p_base+len_nij-1.

Structure
REQ-033 A shared package core_seq_pkg holds:
- the state enum;
- the inst field bit-position constants;
- the idle-word constant.
REQ-034 One sub-module, core_seq_inst_pack, shall assemble inst from the named field signals. It is combinational, and its output is registered in core_seq.

Verification
REQ-035 Scenario 1: reset asserted mid-EXE → inst=34'h1800C0000, busy=0 in the same cycle, with no clock edge needed.
REQ-036 Scenario 2: num_kij=1, len_nij=4, w_base=0, a_base=64, p_base=0, ofifo_valid tied 1 → all of the following:
- xmem reads at 0..7, then 64..67;
- 8 load cycles;
- 4 execute cycles;
- pmem writes at 0..3;
- done exactly once.
REQ-037 Scenario 3: num_kij=0 → done one cycle after busy rises; the idle word is held throughout.
REQ-038 Scenario 4: num_kij=3 with CORE_SEQ_ACC_EN defined → acc=0 on kij 0 writes and acc=1 on kij 1 and 2 writes. Without the macro, acc=0 on all writes.
REQ-039 Scenario 5: ofifo_valid held low for 20 cycles in DRAIN → no ofifo_rd and no pmem write during those cycles; resumes when ofifo_valid rises.
REQ-040 Scenario 6: start pulsed during KWAIT, and p_base=2040 with len_nij=16 → second start ignored; pmem addresses wrap 2040..2047 then 0..7.
